// File: rtl/dirty_line_writeback.sv
// Streams every valid & dirty line of a captured cache snapshot out over a valid/ready port,
// then pulses a clear for that line so the owner can drop its dirty bit.
//
//  state | meaning
//  IDLE  | waiting for start; snapshot captured on start
//  SCAN  | examine one snapshot line per cycle at ptr
//  SEND  | stream words of line ptr, one beat per transfer
//  DONE  | one-cycle done pulse, then back to IDLE
module dirty_line_writeback #(
   parameter int NUM_LINES      = 3,
   parameter int WORDS_PER_LINE = 16,
   parameter int DATA_WIDTH     = 32,
   localparam int LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
   localparam int WORD_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
   input  logic                                           clk,
   input  logic                                           resetn,
   input  logic                                           start,
   input  logic [NUM_LINES*3-1:0]                         meta_in,
   input  logic [NUM_LINES*WORDS_PER_LINE*DATA_WIDTH-1:0] lines_in,
   output logic                                           busy,
   output logic                                           wb_valid,
   input  logic                                           wb_ready,
   output logic [LINE_W-1:0]                              wb_line,
   output logic [WORD_W-1:0]                              wb_word,
   output logic [DATA_WIDTH-1:0]                          wb_data,
   output logic                                           wb_last,
   output logic                                           clr_valid,
   output logic [LINE_W-1:0]                              clr_index,
   output logic                                           done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);

   state_t              state, state_nxt;
   logic [LINE_W-1:0]   ptr, ptr_nxt;
   logic [WORD_W-1:0]   word, word_nxt;
   logic                clr_valid_nxt;
   logic [LINE_W-1:0]   clr_index_nxt;
   logic                capture;
   logic                send;

   logic [DATA_WIDTH-1:0] snap_data [NUM_LINES][WORDS_PER_LINE];
   logic [NUM_LINES-1:0]  snap_vd;
   logic [NUM_LINES-1:0]  meta_vd;
   logic                  unused_accessed;

   // Only valid & dirty matters per line; the accessed bit is deliberately dropped.
   always_comb begin
      meta_vd         = '0;
      unused_accessed = 1'b0;
      for (int l = 0; l < NUM_LINES; l++) begin
         meta_vd[l]      = meta_in[3*l+2] & meta_in[3*l+1];
         unused_accessed = unused_accessed ^ meta_in[3*l];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         snap_vd <= '0;
         for (int l = 0; l < NUM_LINES; l++)
            for (int k = 0; k < WORDS_PER_LINE; k++)
               snap_data[l][k] <= '0;
      end else if (capture) begin
         snap_vd <= meta_vd;
         for (int l = 0; l < NUM_LINES; l++)
            for (int k = 0; k < WORDS_PER_LINE; k++)
               snap_data[l][k] <= lines_in[(l*WORDS_PER_LINE+k)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         ptr       <= '0;
         word      <= '0;
         clr_valid <= 1'b0;
         clr_index <= '0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         word      <= word_nxt;
         clr_valid <= clr_valid_nxt;
         clr_index <= clr_index_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      ptr_nxt       = ptr;
      word_nxt      = word;
      clr_valid_nxt = 1'b0;
      clr_index_nxt = clr_index;
      capture       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               capture   = 1'b1;
               ptr_nxt   = '0;
               word_nxt  = '0;
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (snap_vd[ptr]) begin
               word_nxt  = '0;
               state_nxt = SEND;
            end else if (ptr == LAST_LINE) begin
               state_nxt = DONE;
            end else begin
               ptr_nxt = ptr + LINE_W'(1);
            end
         end
         SEND: begin
            if (wb_ready) begin
               if (word == LAST_WORD) begin
                  clr_valid_nxt = 1'b1;
                  clr_index_nxt = ptr;
                  if (ptr == LAST_LINE) begin
                     state_nxt = DONE;
                  end else begin
                     ptr_nxt   = ptr + LINE_W'(1);
                     state_nxt = SCAN;
                  end
               end else begin
                  word_nxt = word + WORD_W'(1);
               end
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Beat outputs are zeroed outside SEND so nothing stale shows between lines or passes.
   assign send     = (state == SEND);
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign wb_valid = send;
   assign wb_line  = send ? ptr : '0;
   assign wb_word  = send ? word : '0;
   assign wb_data  = send ? snap_data[ptr][word] : '0;
   assign wb_last  = send && (word == LAST_WORD);

endmodule

// File: tb/tb_dirty_line_writeback.sv
// Directed bench for dirty_line_writeback: reset, single line, backpressure, all lines,
// no dirty lines, and start/input changes during a pass.
module tb_dirty_line_writeback;
   localparam int NL = 3;
   localparam int WPL = 16;
   localparam int DW = 32;

   logic                    clk = 1'b0;
   logic                    resetn = 1'b0;
   logic                    start = 1'b0;
   logic [NL*3-1:0]         meta_in = '0;
   logic [NL*WPL*DW-1:0]    lines_in = '0;
   logic                    busy, wb_valid, wb_last, clr_valid, done;
   logic                    wb_ready = 1'b0;
   logic [1:0]              wb_line, clr_index;
   logic [3:0]              wb_word;
   logic [DW-1:0]           wb_data;

   int checks = 0;
   int failures = 0;

   dirty_line_writeback #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL), .DATA_WIDTH(DW)) dut (
      .clk(clk), .resetn(resetn), .start(start), .meta_in(meta_in), .lines_in(lines_in),
      .busy(busy), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_line(wb_line),
      .wb_word(wb_word), .wb_data(wb_data), .wb_last(wb_last), .clr_valid(clr_valid),
      .clr_index(clr_index), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NL*WPL*DW-1:0] pattern();
      logic [NL*WPL*DW-1:0] v;
      v = '0;
      for (int l = 0; l < NL; l++)
         for (int k = 0; k < WPL; k++)
            v[(l*WPL+k)*DW +: DW] = DW'(3*k + l + 1);
      return v;
   endfunction

   task automatic beat(input string tag, input int l, input int k);
      chk({tag, "_valid"}, 64'(wb_valid), 64'(1));
      chk({tag, "_line"},  64'(wb_line),  64'(l));
      chk({tag, "_word"},  64'(wb_word),  64'(k));
      chk({tag, "_data"},  64'(wb_data),  64'(3*k + l + 1));
      chk({tag, "_last"},  64'(wb_last),  64'(k == WPL-1));
      chk({tag, "_clr"},   64'(clr_valid), 64'(0));
   endtask

   task automatic kick();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_valid", 64'(wb_valid), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_clr", 64'(clr_valid), 64'(0));
      step();
      resetn = 1'b1;
      step();
      chk("rel_busy", 64'(busy), 64'(0));
      chk("rel_data", 64'(wb_data), 64'(0));
      chk("rel_clr_index", 64'(clr_index), 64'(0));

      // test 1: reset in mid-SEND
      lines_in = pattern();
      meta_in  = {3'b110, 3'b110, 3'b110};
      wb_ready = 1'b1;
      kick();
      step();
      step();
      step();
      chk("t1_pre_valid", 64'(wb_valid), 64'(1));
      chk("t1_pre_word", 64'(wb_word), 64'(2));
      resetn = 1'b0;
      #1;
      chk("t1_rst_valid", 64'(wb_valid), 64'(0));
      chk("t1_rst_busy", 64'(busy), 64'(0));
      chk("t1_rst_clr", 64'(clr_valid), 64'(0));
      chk("t1_rst_done", 64'(done), 64'(0));
      step();
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t1_post_clr", 64'(clr_valid), 64'(0));
         chk("t1_post_busy", 64'(busy), 64'(0));
      end

      // test 2: single dirty line
      meta_in = {3'b101, 3'b001, 3'b110};
      kick();
      chk("t2_scan_busy", 64'(busy), 64'(1));
      chk("t2_scan_valid", 64'(wb_valid), 64'(0));
      step();
      for (int k = 0; k < WPL; k++) begin
         beat("t2_beat", 0, k);
         step();
      end
      chk("t2_clr_valid", 64'(clr_valid), 64'(1));
      chk("t2_clr_index", 64'(clr_index), 64'(0));
      chk("t2_done_early", 64'(done), 64'(0));
      step();
      chk("t2_clr_pulse", 64'(clr_valid), 64'(0));
      chk("t2_done_t19", 64'(done), 64'(0));
      step();
      chk("t2_done_t20", 64'(done), 64'(1));
      step();
      chk("t2_done_pulse", 64'(done), 64'(0));
      chk("t2_idle", 64'(busy), 64'(0));

      // test 3: backpressure at word 7
      kick();
      step();
      for (int k = 0; k < WPL; k++) begin
         if (k == 7) begin
            wb_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               beat("t3_hold", 0, 7);
               step();
            end
            wb_ready = 1'b1;
         end
         beat("t3_beat", 0, k);
         step();
      end
      chk("t3_clr_valid", 64'(clr_valid), 64'(1));
      chk("t3_clr_index", 64'(clr_index), 64'(0));
      chk("t3_no_extra", 64'(wb_valid), 64'(0));
      step();
      step();
      chk("t3_done", 64'(done), 64'(1));
      step();

      // test 4: all lines dirty
      meta_in = {3'b110, 3'b110, 3'b110};
      kick();
      for (int l = 0; l < NL; l++) begin
         chk("t4_scan_valid", 64'(wb_valid), 64'(0));
         chk("t4_scan_clr", 64'(clr_valid), 64'(l > 0));
         if (l > 0) chk("t4_clr_index", 64'(clr_index), 64'(l - 1));
         step();
         for (int k = 0; k < WPL; k++) begin
            beat("t4_beat", l, k);
            step();
         end
      end
      chk("t4_clr_last", 64'(clr_valid), 64'(1));
      chk("t4_clr_index2", 64'(clr_index), 64'(2));
      chk("t4_done", 64'(done), 64'(1));
      step();
      chk("t4_idle", 64'(busy), 64'(0));
      chk("t4_done_pulse", 64'(done), 64'(0));

      // test 5: dirty without valid, and clean lines
      meta_in = {3'b010, 3'b000, 3'b010};
      kick();
      for (int i = 1; i <= 3; i++) begin
         chk("t5_valid", 64'(wb_valid), 64'(0));
         chk("t5_clr", 64'(clr_valid), 64'(0));
         chk("t5_done_early", 64'(done), 64'(0));
         step();
      end
      chk("t5_done_t4", 64'(done), 64'(1));
      chk("t5_clr_t4", 64'(clr_valid), 64'(0));
      step();
      chk("t5_idle", 64'(busy), 64'(0));

      // test 6: start and input changes during the pass are ignored
      meta_in = {3'b101, 3'b001, 3'b110};
      kick();
      step();
      for (int k = 0; k < WPL; k++) begin
         if (k == 5) begin
            start    = 1'b1;
            lines_in = '1;
            meta_in  = {3'b111, 3'b111, 3'b111};
         end
         if (k == 6) start = 1'b0;
         beat("t6_beat", 0, k);
         step();
      end
      chk("t6_clr_index", 64'(clr_index), 64'(0));
      chk("t6_clr_valid", 64'(clr_valid), 64'(1));
      chk("t6_line1_skip", 64'(wb_valid), 64'(0));
      step();
      chk("t6_line2_skip", 64'(wb_valid), 64'(0));
      step();
      chk("t6_done", 64'(done), 64'(1));
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t6_no_requeue_busy", 64'(busy), 64'(0));
         chk("t6_single_done", 64'(done), 64'(0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end
endmodule
